// File: rtl/dp_freelist_2a2f.sv
// Physical-register free list: circular queue handing out up to two tags per cycle and taking up to two back.
// Zero-cycle allocation from the registered head; frees become allocatable one edge later; overflowing frees are dropped.
module dp_freelist_2a2f #(
    parameter int TAG_WIDTH = 6,
    parameter int DEPTH     = 32,
    parameter int INIT_BASE = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         alloc_req1,
    input  logic                         alloc_req2,
    output logic [TAG_WIDTH-1:0]         alloc_tag1,
    output logic [TAG_WIDTH-1:0]         alloc_tag2,
    output logic                         alloc_ok1,
    output logic                         alloc_ok2,
    input  logic                         free_we1,
    input  logic                         free_we2,
    input  logic [TAG_WIDTH-1:0]         free_tag1,
    input  logic [TAG_WIDTH-1:0]         free_tag2,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TAG_WIDTH-1:0] mem_q [DEPTH];
    logic [TAG_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [AW-1:0]        head_p1, tail_p1;
    logic [CW-1:0]        count_q, count_d, space;
    logic                 err_q, err_d, err_a;
    logic [1:0]           n_a, n_f, n_f_req;
    logic                 wr0_en, wr1_en;
    logic [TAG_WIDTH-1:0] wr0_dat;

    assign head_p1    = head_q + AW'(1);
    assign tail_p1    = tail_q + AW'(1);
    assign alloc_tag1 = mem_q[head_q];
    assign alloc_tag2 = mem_q[head_p1];
    assign alloc_ok1  = (count_q != '0);
    assign alloc_ok2  = (count_q >= CW'(2));
    assign count_o    = count_q;
    assign err_o      = err_q;

    always_comb begin
        n_a   = 2'd0;
        err_a = 1'b0;
        if (alloc_req1) begin
            if (count_q == '0) begin
                err_a = 1'b1;
            end else if (alloc_req2 && (count_q == CW'(1))) begin
                n_a   = 2'd1;
                err_a = 1'b1;
            end else if (alloc_req2) begin
                n_a = 2'd2;
            end else begin
                n_a = 2'd1;
            end
        end else if (alloc_req2) begin
            err_a = 1'b1;
        end

        // Room left after this cycle's pops; frees beyond it are dropped, strobe 1 first.
        space   = CW'(DEPTH) - count_q + CW'(n_a);
        n_f_req = {1'b0, free_we1} + {1'b0, free_we2};
        wr0_en  = (free_we1 | free_we2) && (space != '0);
        wr1_en  = free_we1 && free_we2 && (space >= CW'(2));
        wr0_dat = free_we1 ? free_tag1 : free_tag2;
        n_f     = {1'b0, wr0_en} + {1'b0, wr1_en};

        head_d  = head_q + AW'(n_a);
        tail_d  = tail_q + AW'(n_f);
        count_d = count_q - CW'(n_a) + CW'(n_f);
        err_d   = err_q | err_a | (n_f != n_f_req);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (!rst_ni) begin
                mem_d[i] = TAG_WIDTH'(INIT_BASE + i);
            end else if (wr0_en && (tail_q == AW'(i))) begin
                mem_d[i] = wr0_dat;
            end else if (wr1_en && (tail_p1 == AW'(i))) begin
                mem_d[i] = free_tag2;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(DEPTH);
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_dp_freelist_2a2f.sv
// Directed bench for dp_freelist_2a2f: stimulus queues expected outputs per cycle, a monitor compares them.
module tb_dp_freelist_2a2f;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       alloc_req1, alloc_req2;
    logic [5:0] alloc_tag1, alloc_tag2;
    logic       alloc_ok1, alloc_ok2;
    logic       free_we1, free_we2;
    logic [5:0] free_tag1, free_tag2;
    logic [5:0] count_o;
    logic       err_o;

    dp_freelist_2a2f #(.TAG_WIDTH(6), .DEPTH(32), .INIT_BASE(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_req1(alloc_req1), .alloc_req2(alloc_req2),
        .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
        .alloc_ok1(alloc_ok1), .alloc_ok2(alloc_ok2),
        .free_we1(free_we1), .free_we2(free_we2),
        .free_tag1(free_tag1), .free_tag2(free_tag2),
        .count_o(count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        int sel;
        int exp;
    } exp_t;

    localparam int S_TAG1 = 0, S_TAG2 = 1, S_OK1 = 2, S_OK2 = 3, S_CNT = 4, S_ERR = 5;

    exp_t  sb[$];
    int    cyc = 0;
    int    checks = 0;
    int    passed = 0;
    string names [6] = '{"alloc_tag1", "alloc_tag2", "alloc_ok1", "alloc_ok2", "count_o", "err_o"};

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] pick(int sel);
        case (sel)
            S_TAG1:  return {26'd0, alloc_tag1};
            S_TAG2:  return {26'd0, alloc_tag2};
            S_OK1:   return {31'd0, alloc_ok1};
            S_OK2:   return {31'd0, alloc_ok2};
            S_CNT:   return {26'd0, count_o};
            default: return {31'd0, err_o};
        endcase
    endfunction

    // Monitor: compares every queued expectation belonging to the current cycle.
    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] got;
            e   = sb.pop_front();
            got = pick(e.sel);
            checks++;
            if (got !== 32'(e.exp))
                $display("FAIL %s cycle %0d: got %0d, expected %0d", names[e.sel], e.cyc, got, e.exp);
            else
                passed++;
        end
    end

    task automatic expect_now(int sel, int v);
        sb.push_back('{cyc, sel, v});
    endtask

    task automatic step(bit rst, bit r1, bit r2, bit w1, bit w2, logic [5:0] t1, logic [5:0] t2);
        @(posedge clk_i);
        #1;
        rst_ni     = ~rst;
        alloc_req1 = r1;
        alloc_req2 = r2;
        free_we1   = w1;
        free_we2   = w2;
        free_tag1  = t1;
        free_tag2  = t2;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 6'd0, 6'd0);
    endtask

    // Pops 31 tags from a fresh list: head ends at 31 holding tag 63.
    task automatic drain31();
        for (int i = 0; i < 15; i++) step(0, 1, 1, 0, 0, 6'd0, 6'd0);
        step(0, 1, 0, 0, 0, 6'd0, 6'd0);
    endtask

    initial begin
        rst_ni = 1'b0; alloc_req1 = 0; alloc_req2 = 0; free_we1 = 0; free_we2 = 0;
        free_tag1 = '0; free_tag2 = '0;
        do_reset();
        do_reset();

        // 1: reset values, then three single allocations
        step(0, 1, 0, 0, 0, 6'd0, 6'd0);
        expect_now(S_TAG1, 32); expect_now(S_TAG2, 33); expect_now(S_OK1, 1);
        expect_now(S_OK2, 1);   expect_now(S_CNT, 32);  expect_now(S_ERR, 0);
        step(0, 1, 0, 0, 0, 6'd0, 6'd0); expect_now(S_TAG1, 33);
        step(0, 1, 0, 0, 0, 6'd0, 6'd0); expect_now(S_TAG1, 34);
        idle(); expect_now(S_CNT, 29); expect_now(S_TAG1, 35);
        checks++;
        if (count_o !== 6'd29) $display("FAIL count_o after three allocations: got %0d, expected 29", count_o);
        else passed++;

        // 2: drain to empty in pairs, then underflow
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1, 0, 0, 6'd0, 6'd0);
            expect_now(S_TAG1, 32 + 2 * i); expect_now(S_TAG2, 33 + 2 * i);
            expect_now(S_CNT, 32 - 2 * i);
        end
        idle(); expect_now(S_CNT, 0); expect_now(S_OK1, 0); expect_now(S_OK2, 0); expect_now(S_ERR, 0);
        step(0, 1, 0, 0, 0, 6'd0, 6'd0);
        idle(); expect_now(S_ERR, 1); expect_now(S_CNT, 0);
        checks++;
        if (err_o !== 1'b1) $display("FAIL err_o after underflow: got %0d, expected 1", err_o);
        else passed++;

        // 3: alloc the last tag while freeing two
        do_reset();
        drain31();
        idle(); expect_now(S_CNT, 1); expect_now(S_TAG1, 63); expect_now(S_OK1, 1); expect_now(S_OK2, 0);
        step(0, 1, 0, 1, 1, 6'd5, 6'd9); expect_now(S_TAG1, 63);
        idle(); expect_now(S_CNT, 2); expect_now(S_TAG1, 5); expect_now(S_TAG2, 9); expect_now(S_ERR, 0);

        // 4: wrap-around, head at 31 pairs with entry 0
        do_reset();
        drain31();
        for (int k = 0; k < 15; k++) step(0, 0, 0, 1, 1, 6'(2 * k + 1), 6'(2 * k + 2));
        step(0, 0, 0, 1, 0, 6'd31, 6'd0);
        idle(); expect_now(S_CNT, 32); expect_now(S_TAG1, 63); expect_now(S_TAG2, 1); expect_now(S_ERR, 0);
        for (int j = 0; j < 16; j++) begin
            step(0, 1, 1, 0, 0, 6'd0, 6'd0);
            expect_now(S_TAG1, (j == 0) ? 63 : 2 * j);
            expect_now(S_TAG2, (j == 0) ? 1 : 2 * j + 1);
        end
        idle(); expect_now(S_CNT, 0); expect_now(S_ERR, 0);

        // 5: overflow while full drops both frees
        do_reset();
        step(0, 0, 0, 1, 1, 6'd7, 6'd8); expect_now(S_CNT, 32);
        idle(); expect_now(S_CNT, 32); expect_now(S_ERR, 1); expect_now(S_TAG1, 32); expect_now(S_TAG2, 33);
        checks++;
        if (err_o !== 1'b1) $display("FAIL err_o after overflow: got %0d, expected 1", err_o);
        else passed++;
        step(0, 1, 1, 0, 0, 6'd0, 6'd0); expect_now(S_TAG1, 32); expect_now(S_TAG2, 33);
        idle(); expect_now(S_CNT, 30);

        // 6: reset wins over concurrent alloc and free
        for (int i = 0; i < 11; i++) step(0, 1, 1, 0, 0, 6'd0, 6'd0);
        step(0, 1, 0, 0, 0, 6'd0, 6'd0);
        idle(); expect_now(S_CNT, 7); expect_now(S_ERR, 1);
        step(1, 1, 1, 1, 1, 6'd3, 6'd4);
        idle(); expect_now(S_CNT, 32); expect_now(S_ERR, 0); expect_now(S_TAG1, 32); expect_now(S_TAG2, 33);
        checks++;
        if (count_o !== 6'd32) $display("FAIL count_o after mid-stream reset: got %0d, expected 32", count_o);
        else passed++;
        checks++;
        if (alloc_tag1 !== 6'd32) $display("FAIL alloc_tag1 after mid-stream reset: got %0d, expected 32", alloc_tag1);
        else passed++;

        repeat (3) @(posedge clk_i);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            $display("FAIL %s cycle %0d: never compared, expected %0d", names[e.sel], e.cyc, e.exp);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dp_freelist_2a2f.md
# dp_freelist_2a2f

Physical-register free list for the dispatch stage, sitting directly upstream of the 2-write-port rename map RAM. It supplies up to two free physical tags per cycle to rename (allocation) and accepts up to two released tags per cycle from commit (free). Storage is a circular queue with combinational head read, so allocated tags are available in the same cycle they are requested.

## Interface
- `TAG_WIDTH`, 6, physical tag width.
- `DEPTH`, 32, free-list capacity in entries; power of two, at least 4.
- `INIT_BASE`, 32, first tag loaded at reset; tags `INIT_BASE .. INIT_BASE+DEPTH-1` must fit in `TAG_WIDTH`.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: synchronous reset, active-low.
- `alloc_req1` in 1: consume one tag from the head.
- `alloc_req2` in 1: consume a second tag. Legal only together with `alloc_req1`.
- `alloc_tag1` out TAG_WIDTH: tag at the head.
- `alloc_tag2` out TAG_WIDTH: tag at head+1.
- `alloc_ok1` out 1: count ≥ 1.
- `alloc_ok2` out 1: count ≥ 2.
- `free_we1`, `free_we2` in 1: release-tag strobes.
- `free_tag1`, `free_tag2` in TAG_WIDTH: released tags.
- `count_o` out log2(DEPTH)+1: current number of entries.
- `err_o` out 1: sticky protocol-error flag.

## Operation
- **State:**
  - `head` and `tail` pointers, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - `count` register, 0..DEPTH.
  - entry array of DEPTH×TAG_WIDTH.
  - `err` register.
- **Reset** (`rst_ni`=0 at a clock edge):
  - entry[i] = INIT_BASE+i.
  - head = 0, tail = 0, count = DEPTH, err = 0.
- **Read path:**
  - `alloc_tag1` = entry[head]; `alloc_tag2` = entry[head+1 mod DEPTH].
  - Both are combinational from registered state and always driven, even when not ok.
- **Allocation:**
  - Number popped is n_a = `alloc_req1` + (`alloc_req1` & `alloc_req2`), further limited to the pre-update count.
  - `alloc_req1` with count = 0 pops nothing and sets err.
  - `alloc_req2` with count < 2 pops only the first tag (if present) and sets err.
  - `alloc_req2` without `alloc_req1` pops nothing and sets err.
  - head += n_a.
- **Free:**
  - Only `free_we1`: free_tag1 is written at tail.
  - Only `free_we2`: free_tag2 is written at tail.
  - Both: free_tag1 is written at tail and free_tag2 at tail+1.
  - tail += n_f, where n_f = `free_we1` + `free_we2`.
- **Count:** count_next = count − n_a + n_f.
- **Overflow:**
  - If count − n_a + n_f > DEPTH, the excess frees are dropped, writing `free_we1` first.
  - err is set.
  - count saturates at DEPTH.
- **Simultaneous alloc and free:**
  - Allocation uses pre-update count and entries only. A tag freed this cycle is never allocated in the same cycle.
  - Frees written at tail never collide with the head being read, except when count = 0. In that case the write lands and is readable next cycle.
- **Error flag:** err is sticky until reset. No other behaviour changes after err is set.
- **No duplicate detection:** duplicate tag frees are not detected. Correct releases are the responsibility of commit.

## Timing
- **Allocation latency:** 0 cycles. The tag is valid in the same cycle as `alloc_req*`, and head advances at that cycle's edge.
- **Free-to-allocatable latency:** 1 cycle. A tag freed at edge k is visible at the head no earlier than after edge k.
- **Output update:** all outputs update only at rising edges. `alloc_ok*`, `count_o` and `err_o` are registered-derived with no combinational path from inputs.
- **Reset values:**
  - `alloc_tag1` = INIT_BASE, `alloc_tag2` = INIT_BASE+1.
  - `alloc_ok1` = `alloc_ok2` = 1.
  - `count_o` = DEPTH, `err_o` = 0.
- **Reset mid-operation:** reset overrides any concurrent alloc or free in the same cycle. Full reinitialisation completes in that one edge.
- **Wrap-around:** pointer increments of 1 or 2 wrap modulo DEPTH. head = DEPTH−1 gives `alloc_tag2` from entry[0].

## Test plan
1. **Reset, then single allocations:** assert reset, then `alloc_req1` for 3 cycles → tags 32, 33, 34 are returned and count_o = 29. Check reset values on the first cycle.
2. **Drain to empty:**
   - Run 16 cycles of `alloc_req1`+`alloc_req2` → tags 32..63 in order and count_o = 0.
   - Observe alloc_ok1 = 0 and alloc_ok2 = 0.
   - A further `alloc_req1` → err_o = 1 and count stays 0.
3. **Simultaneous alloc and free at count = 1:**
   - Set up count = 1 with head tag 63.
   - Apply `alloc_req1` together with `free_we1`=1 (tag 5) and `free_we2`=1 (tag 9) → 63 is allocated this cycle.
   - Next cycle count = 2, alloc_tag1 = 5, alloc_tag2 = 9.
4. **Wrap-around:**
   - Drain 31 tags and free tags 1..31 in order.
   - Keep allocating pairs across the head = 31 boundary → alloc_tag2 is taken from entry[0] and tag sequence continuity holds.
5. **Overflow at full:** at count = 32, apply `free_we1`+`free_we2` with no allocation → count_o stays 32, err_o = 1, and the following allocations still return 32, 33.
6. **Reset mid-stream:**
   - With count = 7 and err_o = 1, assert `rst_ni`=0 concurrently with alloc and free.
   - Next cycle count_o = 32, err_o = 0, alloc_tag1 = 32.
